stream_src_ctrl: RTL

//  Session controller for N producer sources feeding one shared CDC buffer.

---
 rtl/stream_src_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/stream_src_ctrl.sv
// Session controller: picks one producer per session, gates it on buffer back-pressure,
// counts written words and waits for the buffer to drain before the next session.
module stream_src_ctrl #(
    parameter int N_SRC     = 2,
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 16,
    parameter int MAX_WORDS = 0,
    localparam int IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        start,
    input  logic                    stop,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic                    buf_full,
    input  logic                    buf_empty,
    input  logic                    rd_valid,
    output logic [N_SRC-1:0]        src_en,
    output logic                    wr_en,
    output logic [DATA_W-1:0]       wr_data,
    output logic [IDX_W-1:0]        act_idx,
    output logic [1:0]              state,
    output logic [3:0]              led,
    output logic [CNT_W-1:0]        word_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COMM  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((MAX_WORDS == 0) ? 0 : MAX_WORDS - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_t              state_q, state_d;
    logic [N_SRC-1:0]    start_prev;
    logic                stop_prev;
    logic [N_SRC-1:0]    start_edge;
    logic                stop_edge;
    logic [IDX_W-1:0]    first_idx;
    logic                sel_valid;
    logic [DATA_W-1:0]   sel_data;
    logic                limit_hit;
    logic                session_start;

    // Prev-level flops reset high so a button held through reset never fires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_prev <= '1;
            stop_prev  <= 1'b1;
        end else begin
            start_prev <= start;
            stop_prev  <= stop;
        end
    end

    assign start_edge = start & ~start_prev;
    assign stop_edge  = stop & ~stop_prev;

    always_comb begin
        first_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (start_edge[i]) first_idx = IDX_W'(i);
        end
    end

    always_comb begin
        src_en    = '0;
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (act_idx == IDX_W'(i)) begin
                src_en[i] = (state_q == COMM) && !buf_full;
                sel_valid = src_valid[i];
                sel_data  = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_en     = (|src_en) && sel_valid;
    assign wr_data   = wr_en ? sel_data : '0;
    assign limit_hit = (MAX_WORDS != 0) && wr_en && (word_cnt == LIMIT_M1);
    assign session_start = (state_q == IDLE) && (|start_edge);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (|start_edge) state_d = COMM;
            COMM: begin
                if (stop_edge)      state_d = DRAIN;
                else if (limit_hit) state_d = DRAIN;
                else if (buf_full)  state_d = WAIT;
            end
            WAIT: begin
                if (stop_edge)      state_d = DRAIN;
                else if (!buf_full) state_d = COMM;
            end
            DRAIN: if (buf_empty && !rd_valid) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            act_idx  <= '0;
            word_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (session_start) begin
                act_idx  <= first_idx;
                word_cnt <= '0;
            end else if (wr_en) begin
                word_cnt <= sat_inc(word_cnt);
            end
        end
    end

    assign state = state_q;
    assign led   = 4'b0001 << state_q;

endmodule
